// File: rtl/bit_write_arbiter_if.sv
// Request/grant bus for bit_write_arbiter: per-requester bit writes in,
// shared register state and range-error status out.
interface bit_write_arbiter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDXW  = 4
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*IDXW-1:0] req_idx;
    logic [NREQ-1:0]      req_val;
    logic [WIDTH-1:0]     thing;
    logic [2:0]           grant_id;
    logic                 err_oor;
    logic [7:0]           oor_count;

    modport master (
        output req_valid, req_idx, req_val,
        input  req_ready, thing, grant_id, err_oor, oor_count
    );

    modport slave (
        input  req_valid, req_idx, req_val,
        output req_ready, thing, grant_id, err_oor, oor_count
    );
endinterface

// File: rtl/bit_write_arbiter.sv
// Round-robin arbiter granting one single-bit set/clear per cycle into a shared
// register; out-of-range indices are consumed, flagged and counted.
module bit_write_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 3,
    parameter int unsigned IDXW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bit_write_arbiter_if.slave   bus
);
    localparam int unsigned PTRW = 3;
    localparam int unsigned CNTW = 8;

    logic [PTRW-1:0]  r_ptr;
    logic [WIDTH-1:0] r_thing;
    logic [PTRW-1:0]  r_grant_id;
    logic             r_err_oor;
    logic [CNTW-1:0]  r_oor_count;

    logic [NREQ-1:0]  w_ready;
    logic             w_found;
    logic [PTRW-1:0]  w_gnt;
    logic [IDXW-1:0]  w_idx;
    logic             w_val;
    logic             w_in_range;
    logic [WIDTH-1:0] w_thing_nxt;
    logic [PTRW-1:0]  w_ptr_nxt;

    // Rotating search from r_ptr; first valid requester wins. Blocked during reset.
    always_comb begin
        w_ready = '0;
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = '0;
        w_val   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int r = 0; r < NREQ; r++) begin
                if (!w_found && !rst && bus.req_valid[r] &&
                    ((32'(r_ptr) + 32'(k)) % NREQ) == 32'(r)) begin
                    w_found    = 1'b1;
                    w_ready[r] = 1'b1;
                    w_gnt      = PTRW'(r);
                    w_idx      = bus.req_idx[r*IDXW +: IDXW];
                    w_val      = bus.req_val[r];
                end
            end
        end
    end

    assign w_in_range = 32'(w_idx) < WIDTH;

    always_comb begin
        w_thing_nxt = r_thing;
        for (int b = 0; b < WIDTH; b++) begin
            if (w_found && w_in_range && 32'(w_idx) == 32'(b)) begin
                w_thing_nxt[b] = w_val;
            end
        end
    end

    assign w_ptr_nxt = (32'(w_gnt) == NREQ - 1) ? '0 : w_gnt + PTRW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr       <= '0;
            r_thing     <= '0;
            r_grant_id  <= '0;
            r_err_oor   <= 1'b0;
            r_oor_count <= '0;
        end else begin
            r_thing   <= w_thing_nxt;
            r_err_oor <= w_found && !w_in_range;
            if (w_found) begin
                r_ptr      <= w_ptr_nxt;
                r_grant_id <= w_gnt;
            end
            // Dropped writes saturate rather than wrap
            if (w_found && !w_in_range && r_oor_count != {CNTW{1'b1}}) begin
                r_oor_count <= r_oor_count + CNTW'(1);
            end
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.thing     = r_thing;
    assign bus.grant_id  = r_grant_id;
    assign bus.err_oor   = r_err_oor;
    assign bus.oor_count = r_oor_count;
endmodule

// File: tb/tb_bit_write_arbiter.sv
// Directed bench for bit_write_arbiter with a queue scoreboard checked by an
// independent monitor one cycle after each observed handshake.
module tb_bit_write_arbiter;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 3;
    localparam int unsigned IDXW  = 4;

    typedef struct {
        logic [2:0] gid;
        logic [7:0] thing;
        logic       err;
        logic [7:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    exp_t q[$];
    logic pending;

    bit_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ), .IDXW(IDXW)) bus ();

    bit_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic [7:0] t, input logic e, input logic [7:0] c);
        exp_t x;
        x.gid = g; x.thing = t; x.err = e; x.cnt = c;
        q.push_back(x);
    endtask

    task automatic set_req(input int r, input logic [3:0] idx, input logic v);
        bus.req_idx[r*IDXW +: IDXW] = idx;
        bus.req_val[r]   = v;
        bus.req_valid[r] = 1'b1;
    endtask

    // Each requester drops valid right after its own acceptance.
    task automatic drain(input int budget);
        logic [NREQ-1:0] acc;
        int n;
        n = 0;
        while (bus.req_valid != '0 && n < budget) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            @(posedge clk);
            #1;
            bus.req_valid = bus.req_valid & ~acc;
            n++;
        end
        if (bus.req_valid != '0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: valid=0x%0h still pending after %0d cycles", bus.req_valid, budget);
            bus.req_valid = '0;
        end
    endtask

    // Monitor: results of a handshake become visible on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        chk("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
        if (pending) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_xfer: grant_id=%0d thing=0x%0h, expected no transfer", bus.grant_id, bus.thing);
            end else begin
                e = q.pop_front();
                chk("grant_id", 32'(bus.grant_id), 32'(e.gid));
                chk("thing", 32'(bus.thing), 32'(e.thing));
                chk("err_oor", 32'(bus.err_oor), 32'(e.err));
                chk("oor_count", 32'(bus.oor_count), 32'(e.cnt));
            end
        end else if (!rst) begin
            chk("err_oor_idle", 32'(bus.err_oor), 32'd0);
        end
        pending = |(bus.req_valid & bus.req_ready);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        pending = 1'b0;
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_idx   = '0;
        bus.req_val   = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_thing", 32'(bus.thing), 32'h00);
        chk("rst_ready", 32'(bus.req_ready), 32'h0);
        chk("rst_err", 32'(bus.err_oor), 32'h0);
        chk("rst_cnt", 32'(bus.oor_count), 32'h0);
        chk("rst_gid", 32'(bus.grant_id), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single in-range writes
        push(3'd0, 8'h01, 1'b0, 8'd0); set_req(0, 4'd0, 1'b1); drain(10);
        push(3'd0, 8'h05, 1'b0, 8'd0); set_req(0, 4'd2, 1'b1); drain(10);
        push(3'd0, 8'h04, 1'b0, 8'd0); set_req(0, 4'd0, 1'b0); drain(10);
        repeat (2) @(posedge clk); #1;

        // Reset, then round-robin among three continuously valid requesters
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(3'd0, 8'h01, 1'b0, 8'd0);
        push(3'd1, 8'h03, 1'b0, 8'd0);
        push(3'd2, 8'h07, 1'b0, 8'd0);
        set_req(0, 4'd0, 1'b1); set_req(1, 4'd1, 1'b1); set_req(2, 4'd2, 1'b1);
        drain(10);

        // r0 and r2 held valid, r1 idle: grants alternate r0, r2
        push(3'd0, 8'h0F, 1'b0, 8'd0);
        push(3'd2, 8'h1F, 1'b0, 8'd0);
        push(3'd0, 8'h1F, 1'b0, 8'd0);
        push(3'd2, 8'h1F, 1'b0, 8'd0);
        set_req(0, 4'd3, 1'b1); set_req(2, 4'd4, 1'b1);
        repeat (4) @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk); #1;

        // Out-of-range drop from thing=0x05, then an in-range write
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        push(3'd0, 8'h01, 1'b0, 8'd0); set_req(0, 4'd0, 1'b1); drain(10);
        push(3'd0, 8'h05, 1'b0, 8'd0); set_req(0, 4'd2, 1'b1); drain(10);
        push(3'd1, 8'h05, 1'b1, 8'd1); set_req(1, 4'd9, 1'b1); drain(10);
        push(3'd1, 8'h85, 1'b0, 8'd1); set_req(1, 4'd7, 1'b1); drain(10);
        repeat (2) @(posedge clk); #1;

        // 260 consecutive out-of-range writes: counter saturates at 255
        for (int i = 0; i < 260; i++) begin
            push(3'd2, 8'h85, 1'b1, (i + 2 > 255) ? 8'd255 : 8'(i + 2));
        end
        set_req(2, 4'd15, 1'b0);
        repeat (260) @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (2) @(posedge clk); #1;

        // No-op write (bit already set) moves the pointer to 1
        push(3'd0, 8'h85, 1'b0, 8'd255); set_req(0, 4'd0, 1'b1); drain(10);

        // Reset coinciding with a valid request: nothing accepted, pointer back to 0
        rst = 1'b1;
        set_req(2, 4'd7, 1'b1);
        @(negedge clk);
        chk("rst_mid_ready", 32'(bus.req_ready), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(3'd0, 8'h08, 1'b0, 8'd0);
        push(3'd2, 8'h88, 1'b0, 8'd0);
        set_req(0, 4'd3, 1'b1);
        drain(10);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
